// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port, with a pending-write
// scoreboard so decode can see RAW hazards on long-latency (port-1) destinations.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [REG_ADDR_W-1:0] p0_addr,
    input  logic [XLEN-1:0]       p0_data,

    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [REG_ADDR_W-1:0] p1_addr,
    input  logic [XLEN-1:0]       p1_data,

    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_addr,

    input  logic [REG_ADDR_W-1:0] q_addr1,
    input  logic [REG_ADDR_W-1:0] q_addr2,
    output logic                  q_busy1,
    output logic                  q_busy2,

    output logic [REG_ADDR_W-1:0] a3,
    output logic                  we3,
    output logic [XLEN-1:0]       wd3
);

    localparam int NREG  = 2 ** REG_ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;

    logic p0_wr;
    logic p1_wr;
    logic conflict;
    logic p1_starved;
    logic p0_acc;
    logic p1_acc;
    logic iss_set;

    // Arbitration: x0 requests never compete for the port, so only two real writes conflict.
    always_comb begin
        p0_wr      = p0_valid && (p0_addr != '0);
        p1_wr      = p1_valid && (p1_addr != '0);
        conflict   = p0_wr && p1_wr;
        p1_starved = (starve_cnt == LIMIT);
        p0_ready   = !(conflict && p1_starved);
        p1_ready   = !(conflict && !p1_starved);
        p0_acc     = p0_wr && p0_ready;
        p1_acc     = p1_wr && p1_ready;
        iss_set    = iss_valid && (iss_addr != '0);
    end

    // Output register feeding register_file's write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a3  <= '0;
            we3 <= 1'b0;
            wd3 <= '0;
        end else if (p0_acc) begin
            a3  <= p0_addr;
            we3 <= 1'b1;
            wd3 <= p0_data;
        end else if (p1_acc) begin
            a3  <= p1_addr;
            we3 <= 1'b1;
            wd3 <= p1_data;
        end else begin
            we3 <= 1'b0;
        end
    end

    // A blocked port-1 request implies p1_wr, so only valid-and-waiting cycles count up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!p1_valid || p1_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Scoreboard: a fresh issue to the same register supersedes a completing one.
    always_comb begin
        busy_nxt = busy;
        if (p1_acc) begin
            busy_nxt[p1_addr] = 1'b0;
        end
        if (iss_set) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // The we3 term covers the cycle where the write sits in the output register
    // and register_file has not yet taken it.
    always_comb begin
        q_busy1 = (q_addr1 != '0) && (busy[q_addr1] || (we3 && (a3 == q_addr1)));
        q_busy2 = (q_addr2 != '0) && (busy[q_addr2] || (we3 && (a3 == q_addr2)));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a rule-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int LIM  = 4;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            p0_valid, p0_ready;
    logic [AW-1:0]   p0_addr;
    logic [XLEN-1:0] p0_data;
    logic            p1_valid, p1_ready;
    logic [AW-1:0]   p1_addr;
    logic [XLEN-1:0] p1_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_addr;
    logic [AW-1:0]   q_addr1, q_addr2;
    logic            q_busy1, q_busy2;
    logic [AW-1:0]   a3;
    logic            we3;
    logic [XLEN-1:0] wd3;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .REG_ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .a3(a3), .we3(we3), .wd3(wd3)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: starvation wait count, pending set, and the last write handed to register_file.
    int              m_starve = 0;
    bit              m_busy[NREG];
    bit              m_we = 1'b0;
    logic [AW-1:0]   m_a  = '0;
    logic [XLEN-1:0] m_wd = '0;

    wire want0 = p0_valid && (p0_addr != 0);
    wire want1 = p1_valid && (p1_addr != 0);
    wire e_rdy0 = !(want0 && want1 && (m_starve >= LIM));
    wire e_rdy1 = !(want0 && want1 && (m_starve < LIM));
    wire e_qb1 = (q_addr1 != 0) && (m_busy[q_addr1] || (m_we && (m_a == q_addr1)));
    wire e_qb2 = (q_addr2 != 0) && (m_busy[q_addr2] || (m_we && (m_a == q_addr2)));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_starve <= 0;
            m_we     <= 1'b0;
            m_a      <= '0;
            m_wd     <= '0;
            for (int i = 0; i < NREG; i++) m_busy[i] <= 1'b0;
        end else begin
            if (want0 && e_rdy0) begin
                m_we <= 1'b1; m_a <= p0_addr; m_wd <= p0_data;
            end else if (want1 && e_rdy1) begin
                m_we <= 1'b1; m_a <= p1_addr; m_wd <= p1_data;
            end else begin
                m_we <= 1'b0;
            end
            if (!p1_valid || e_rdy1) m_starve <= 0;
            else m_starve <= (m_starve < LIM) ? m_starve + 1 : LIM;
            for (int i = 1; i < NREG; i++) begin
                if (iss_valid && iss_addr == i) m_busy[i] <= 1'b1;
                else if (want1 && e_rdy1 && p1_addr == i) m_busy[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc p0_ready", p0_ready, e_rdy0);
            check("cyc p1_ready", p1_ready, e_rdy1);
            check("cyc we3", we3, m_we);
            check("cyc a3", a3, m_a);
            check("cyc wd3", wd3, m_wd);
            check("cyc q_busy1", q_busy1, e_qb1);
            check("cyc q_busy2", q_busy2, e_qb2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int blocked;
    bit got;

    initial begin
        rst = 1'b1;
        p0_valid = 0; p0_addr = 0; p0_data = 0;
        p1_valid = 0; p1_addr = 0; p1_data = 0;
        iss_valid = 0; iss_addr = 0; q_addr1 = 7; q_addr2 = 0;
        #2;
        // readiness follows the arbitration rule even while in reset
        p0_valid = 1; p0_addr = 3; p1_valid = 1; p1_addr = 4;
        #1;
        check("rst p0_ready", p0_ready, 1);
        check("rst p1_ready", p1_ready, 0);
        check("rst we3", we3, 0);
        check("rst a3", a3, 0);
        check("rst wd3", wd3, 0);
        check("rst q_busy1", q_busy1, 0);
        p0_valid = 0; p1_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // single writes
        p0_valid = 1; p0_addr = 1; p0_data = 200;
        #1 check("w1 p0_ready", p0_ready, 1);
        cyc();
        check("w1 we3", we3, 1); check("w1 a3", a3, 1); check("w1 wd3", wd3, 200);
        p0_addr = 0; p0_data = 55;
        #1 check("x0 p0_ready", p0_ready, 1);
        cyc();
        check("x0 we3", we3, 0); check("x0 a3 hold", a3, 1); check("x0 wd3 hold", wd3, 200);
        p0_valid = 0;

        // conflict: port 0 first, then port 1
        p0_valid = 1; p0_addr = 3; p0_data = 100;
        p1_valid = 1; p1_addr = 4; p1_data = 150;
        #1 check("cf p0_ready", p0_ready, 1); check("cf p1_ready", p1_ready, 0);
        cyc();
        p0_valid = 0;
        check("cf1 a3", a3, 3); check("cf1 wd3", wd3, 100); check("cf1 we3", we3, 1);
        #1 check("cf2 p1_ready", p1_ready, 1);
        cyc();
        p1_valid = 0;
        check("cf2 a3", a3, 4); check("cf2 wd3", wd3, 150); check("cf2 we3", we3, 1);

        // starvation: p1 held off for exactly LIM cycles, then overrides p0
        p1_valid = 1; p1_addr = 5; p1_data = 77;
        p0_valid = 1;
        blocked = 0; got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            p0_addr = AW'(8 + i); p0_data = 1000 + i;
            #1;
            if (p1_ready) begin
                got = 1;
                check("sv p0_ready", p0_ready, 0);
            end else begin
                blocked++;
                cyc();
            end
        end
        check("sv p1 granted", got, 1);
        check("sv blocked cycles", blocked, 4);
        cyc();
        check("sv a3", a3, 5); check("sv wd3", wd3, 77);
        p1_data = 78;
        #1 check("sv cnt cleared", p1_ready, 0);
        cyc();
        check("sv p0 held a3", a3, 12); check("sv p0 held wd3", wd3, 1004);
        p0_valid = 0; p1_valid = 0;

        // scoreboard
        iss_valid = 1; iss_addr = 7; q_addr1 = 7;
        #1 check("sb pre-issue", q_busy1, 0);
        cyc();
        iss_valid = 0;
        #1 check("sb issued", q_busy1, 1);
        p1_valid = 1; p1_addr = 7; p1_data = 9;
        #1 check("sb p1_ready", p1_ready, 1);
        cyc();
        p1_valid = 0;
        #1 check("sb in output reg", q_busy1, 1);
        check("sb we3", we3, 1); check("sb a3", a3, 7);
        cyc();
        check("sb landed", q_busy1, 0);
        iss_valid = 1; iss_addr = 7;
        cyc();
        p1_valid = 1; p1_addr = 7; p1_data = 1;
        cyc();
        iss_valid = 0; p1_valid = 0;
        cyc();
        check("sb set wins", q_busy1, 1);
        p1_valid = 1; p1_addr = 7; p1_data = 2;
        cyc();
        p1_valid = 0;
        cyc();
        check("sb cleared", q_busy1, 0);
        iss_valid = 1; iss_addr = 9;
        cyc();
        iss_valid = 0; q_addr2 = 9;
        #1 check("sb r9 busy", q_busy2, 1);

        // x0 request overlapping a real write
        p0_valid = 1; p0_addr = 2; p0_data = 10;
        p1_valid = 1; p1_addr = 0; p1_data = 11;
        q_addr1 = 0;
        #1 check("ov p0_ready", p0_ready, 1); check("ov p1_ready", p1_ready, 1);
        check("ov q0", q_busy1, 0);
        cyc();
        p0_valid = 0; p1_valid = 0;
        check("ov a3", a3, 2); check("ov wd3", wd3, 10); check("ov we3", we3, 1);
        q_addr2 = 2;
        #1 check("ov r2 pending", q_busy2, 1);
        q_addr2 = 9;
        #1 check("ov r9 unchanged", q_busy2, 1);
        cyc();
        check("ov we3 off", we3, 0);

        // reset drops an in-flight write and clears the scoreboard
        p0_valid = 1; p0_addr = 6; p0_data = 42;
        cyc();
        p0_valid = 0;
        check("rm we3 before", we3, 1);
        #1 rst = 1'b1;
        #1 check("rm we3", we3, 0); check("rm a3", a3, 0); check("rm wd3", wd3, 0);
        check("rm busy", q_busy2, 0);
        #1 rst = 1'b0;
        cyc();
        p0_valid = 1; p0_addr = 6; p0_data = 42;
        #2 rst = 1'b1;
        #1 check("rb we3", we3, 0);
        cyc();
        check("rb edge we3", we3, 0); check("rb edge a3", a3, 0);
        rst = 1'b0; p0_valid = 0;
        cyc();
        check("rb never written", we3, 0);

        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (a3/we3/wd3) between two writeback sources.
- Port 0: in-order pipeline writeback.
- Port 1: long-latency unit (load/mul-div).

It also keeps a pending-write scoreboard so decode can detect RAW hazards on registers whose port-1 result has not yet landed. It sits between the writeback sources and register_file. Its outputs drive register_file's write port directly.

Parameters:
XLEN, 32, data width of the write port
REG_ADDR_W, 5, register address width (2**REG_ADDR_W registers, x0 hardwired zero)
STARVE_LIMIT, 4, consecutive port-1 wait cycles after which port 1 overrides port 0 priority

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
p0_valid  in  1  port-0 write request
p0_ready  out  1  port-0 request accepted this cycle (combinational)
p0_addr  in  REG_ADDR_W  port-0 destination register
p0_data  in  XLEN  port-0 write data
p1_valid  in  1  port-1 write request
p1_ready  out  1  port-1 request accepted this cycle (combinational)
p1_addr  in  REG_ADDR_W  port-1 destination register
p1_data  in  XLEN  port-1 write data
iss_valid  in  1  port-1 operation issued; marks iss_addr pending
iss_addr  in  REG_ADDR_W  destination of issued port-1 operation
q_addr1  in  REG_ADDR_W  hazard query address 1
q_addr2  in  REG_ADDR_W  hazard query address 2
q_busy1  out  1  q_addr1 has a write not yet committed to register_file
q_busy2  out  1  q_addr2 has a write not yet committed to register_file
a3  out  REG_ADDR_W  register_file write address (registered)
we3  out  1  register_file write enable (registered)
wd3  out  XLEN  register_file write data (registered)

Behaviour:
Reset:
- rst high, asynchronous: a3=0, we3=0, wd3=0, all busy bits 0, starvation counter 0.
- Any in-flight write in the output register is dropped.
- p0_ready/p1_ready follow the combinational rules below even while rst is high.

Acceptance:
- A transfer happens when valid && ready.
- ready is combinational from valid, addr and the starvation counter.
- The block never stalls a source except on the port conflict.

x0 requests:
- A request with addr==0 is always accepted (ready=1) and discarded.
- It does not occupy the write port.
- It can be accepted in the same cycle as the other port's nonzero request.

Conflict (both valid, both addr!=0):
- Port 0 wins unless starve_cnt==STARVE_LIMIT; then port 1 wins.
- The loser sees ready=0 and must hold valid/addr/data stable.

Output stage:
- The accepted nonzero request is registered: a3/wd3 take addr/data and we3=1 on the next edge.
- register_file commits on the following edge.
- Latency, accept to committed: 2 edges.
- If no nonzero request is accepted: we3=0; a3/wd3 hold their previous values.

Starvation counter:
- Increments, saturating at STARVE_LIMIT, each cycle p1_valid && p1_addr!=0 && !p1_ready.
- Clears on a port-1 accept or when !p1_valid.

Scoreboard (busy[1..2**REG_ADDR_W-1], busy[0] constant 0):
- iss_valid && iss_addr!=0 sets busy[iss_addr].
- A port-1 accept with addr!=0 clears busy[p1_addr].
- A same-cycle set and clear to the same address: set wins (a new issue supersedes the old).
- Port-0 accepts do not touch busy.
- q_busyN = busy[q_addrN] || (we3 && a3==q_addrN && q_addrN!=0), combinational.
- The we3 term covers the cycle where the write is registered but register_file still holds the old value.
- q_addrN==0 gives q_busyN=0.

Test Plan:
- Reset then single writes: p0 {addr 1, data 200} -> p0_ready=1; next edge we3=1, a3=1, wd3=200; following cycle we3=0. p0 {addr 0, data 55} -> ready=1, we3 stays 0.
- Conflict: p0 {3, 100} and p1 {4, 150} valid together -> cycle 1 p0_ready=1, p1_ready=0. Cycle 2 p1 accepted. Output sequence: a3=3/wd3=100, then a3=4/wd3=150.
- Starvation: p0 valid nonzero every cycle, p1 {5, 77} held valid -> p1_ready=0 for exactly 4 cycles, then p1_ready=1 with p0_ready=0; counter back to 0.
- Scoreboard: iss {7}, then q_addr1=7 -> q_busy1=1. p1 {7, 9} accepted -> q_busy1 stays 1 while we3=1, a3=7, then 0. Same-cycle iss 7 + p1 accept 7 -> busy[7] stays 1.
- x0 overlap: p0 {2, 10} and p1 {0, 11} simultaneously -> both ready=1; only a3=2, wd3=10 written; busy unchanged; q_addr=0 -> q_busy=0.
- Reset mid-operation: p0 {6, 42} accepted, rst asserted before next edge -> we3=0 immediately; busy all 0; register 6 never written.
